// File: rtl/multi_raz_generator.sv
// Multi-channel RAZ pulse generator.
// Each channel synchronises its trigger and detects rising edges. An accepted
// edge starts a programmable delay, then a RAZ pulse, then a holdoff. ForceRaz
// overrides every channel. A shared saturating counter records RAZ events.
module multi_raz_generator #(
  parameter int N_CHN   = 4,
  parameter int DELAY_W = 6,
  parameter int WIDTH_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic [N_CHN-1:0]   TriggerIn,
  input  logic               ExternalRaz_en,
  input  logic [N_CHN-1:0]   ChannelMask,
  input  logic [DELAY_W-1:0] DelayTime,
  input  logic [WIDTH_W-1:0] RazWidth,
  input  logic [WIDTH_W-1:0] HoldoffTime,
  input  logic               ForceRaz,
  input  logic               CountClear,
  output logic [N_CHN-1:0]   RAZ_CHN,
  output logic [N_CHN-1:0]   Busy,
  output logic [CNT_W-1:0]   RazCount
);

  // One timer serves the delay, pulse and holdoff phases, so it must hold the wider field.
  localparam int CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam logic [CW-1:0]      TIMER_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = {{(WIDTH_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } razStateT;

  // A zero pulse width still produces a one-cycle pulse.
  function automatic logic [WIDTH_W-1:0] minOneWidth(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? WIDTH_ONE : w;
  endfunction

  logic [N_CHN-1:0]   syncMeta;
  logic [N_CHN-1:0]   syncLevel;
  logic [N_CHN-1:0]   prevLevel;
  logic [N_CHN-1:0]   trigEdge;
  razStateT           stateReg  [N_CHN];
  razStateT           stateNext [N_CHN];
  logic [CW-1:0]      timerReg  [N_CHN];
  logic [CW-1:0]      timerNext [N_CHN];
  logic [WIDTH_W-1:0] widthReg  [N_CHN];
  logic [WIDTH_W-1:0] widthNext [N_CHN];
  logic [WIDTH_W-1:0] holdReg   [N_CHN];
  logic [WIDTH_W-1:0] holdNext  [N_CHN];
  logic [N_CHN-1:0]   razNext;
  logic [N_CHN-1:0]   busyNext;
  logic [N_CHN-1:0]   pulseEnter;
  logic [CNT_W-1:0]   countNext;

  assign trigEdge = syncLevel & ~prevLevel;

  // Two-flop synchroniser plus edge-detect history; resets high so a held trigger gives no edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta  <= '1;
      syncLevel <= '1;
      prevLevel <= '1;
    end else begin
      syncMeta  <= TriggerIn;
      syncLevel <= syncMeta;
      prevLevel <= syncLevel;
    end
  end

  // Per-channel sequencing: accept edge, count delay, pulse, holdoff; ForceRaz aborts all.
  always_comb begin
    stateNext  = stateReg;
    timerNext  = timerReg;
    widthNext  = widthReg;
    holdNext   = holdReg;
    razNext    = '0;
    busyNext   = '0;
    pulseEnter = '0;
    for (int i = 0; i < N_CHN; i++) begin
      if (ForceRaz) begin
        stateNext[i] = IDLE;
        timerNext[i] = '0;
      end else begin
        case (stateReg[i])
          IDLE: begin
            if (trigEdge[i] && ExternalRaz_en && ChannelMask[i]) begin
              widthNext[i] = minOneWidth(RazWidth);
              holdNext[i]  = HoldoffTime;
              if (DelayTime == '0) begin
                stateNext[i] = PULSE;
                timerNext[i] = CW'(minOneWidth(RazWidth)) - TIMER_ONE;
              end else begin
                stateNext[i] = DELAY;
                timerNext[i] = CW'(DelayTime) - TIMER_ONE;
              end
            end else begin
              stateNext[i] = IDLE;
            end
          end
          DELAY: begin
            if (timerReg[i] == '0) begin
              stateNext[i] = PULSE;
              timerNext[i] = CW'(widthReg[i]) - TIMER_ONE;
            end else begin
              timerNext[i] = timerReg[i] - TIMER_ONE;
            end
          end
          PULSE: begin
            if (timerReg[i] == '0) begin
              if (holdReg[i] == '0) begin
                stateNext[i] = IDLE;
              end else begin
                stateNext[i] = HOLDOFF;
                timerNext[i] = CW'(holdReg[i]) - TIMER_ONE;
              end
            end else begin
              timerNext[i] = timerReg[i] - TIMER_ONE;
            end
          end
          HOLDOFF: begin
            if (timerReg[i] == '0) begin
              stateNext[i] = IDLE;
            end else begin
              timerNext[i] = timerReg[i] - TIMER_ONE;
            end
          end
          default: begin
            stateNext[i] = IDLE;
            timerNext[i] = '0;
          end
        endcase
      end
      razNext[i]    = (stateNext[i] == PULSE);
      busyNext[i]   = (stateNext[i] != IDLE);
      pulseEnter[i] = (stateNext[i] == PULSE) && (stateReg[i] != PULSE);
    end
  end

  // Shared event counter: clear wins, simultaneous entries count once, saturates at all ones.
  always_comb begin
    countNext = RazCount;
    if (CountClear) begin
      countNext = '0;
    end else if ((|pulseEnter) && (RazCount != '1)) begin
      countNext = RazCount + CNT_ONE;
    end else begin
      countNext = RazCount;
    end
  end

  // Channel state registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHN; i++) begin
        stateReg[i] <= IDLE;
        timerReg[i] <= '0;
        widthReg[i] <= '0;
        holdReg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHN; i++) begin
        stateReg[i] <= stateNext[i];
        timerReg[i] <= timerNext[i];
        widthReg[i] <= widthNext[i];
        holdReg[i]  <= holdNext[i];
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      RAZ_CHN  <= '0;
      Busy     <= '0;
      RazCount <= '0;
    end else begin
      RAZ_CHN  <= ForceRaz ? '1 : razNext;
      Busy     <= busyNext;
      RazCount <= countNext;
    end
  end

endmodule

// File: tb/tb_multi_raz_generator.sv
// Scoreboard bench for multi_raz_generator: a timeline model predicts outputs per cycle.
module tb_multi_raz_generator;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int WW = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  TriggerIn;
  logic          ExternalRaz_en;
  logic [N-1:0]  ChannelMask;
  logic [DW-1:0] DelayTime;
  logic [WW-1:0] RazWidth;
  logic [WW-1:0] HoldoffTime;
  logic          ForceRaz;
  logic          CountClear;
  logic [N-1:0]  RAZ_CHN;
  logic [N-1:0]  Busy;
  logic [CW-1:0] RazCount;

  multi_raz_generator #(.N_CHN(N), .DELAY_W(DW), .WIDTH_W(WW), .CNT_W(CW)) dut (
    .Clk(Clk), .reset_n(reset_n), .TriggerIn(TriggerIn), .ExternalRaz_en(ExternalRaz_en),
    .ChannelMask(ChannelMask), .DelayTime(DelayTime), .RazWidth(RazWidth),
    .HoldoffTime(HoldoffTime), .ForceRaz(ForceRaz), .CountClear(CountClear),
    .RAZ_CHN(RAZ_CHN), .Busy(Busy), .RazCount(RazCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0]  raz;
    logic [N-1:0]  busy;
    logic [CW-1:0] cnt;
  } expT;

  expT expQ[$];
  expT me;
  int  compared = 0;
  int  mismatched = 0;
  bit  monOn = 1'b0;
  int  razObs0 = 0;
  int  busyObs0 = 0;

  // Reference model: each channel remembers when it accepted an edge and its latched times.
  bit           act  [N];
  longint       accT [N];
  int           dLat [N];
  int           wLat [N];
  int           hLat [N];
  logic [N-1:0] h0, h1, h2;
  bit           forcedNow;
  int           modelCount;
  longint       cyc;

  function void check(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function bit chBusy(int i, longint c);
    return act[i] && (c >= accT[i] + 1) && (c <= accT[i] + dLat[i] + wLat[i] + hLat[i]);
  endfunction

  function bit chPulse(int i, longint c);
    return act[i] && (c >= accT[i] + 1 + dLat[i]) && (c <= accT[i] + dLat[i] + wLat[i]);
  endfunction

  // Predict this cycle's outputs from current inputs, then advance one clock.
  task automatic cycleStep();
    expT e;
    bit  enter;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) act[i] = 1'b0;
      h0 = '1; h1 = '1; h2 = '1;
      modelCount = 0;
      e.raz = '0; e.busy = '0; e.cnt = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        e.raz[i]  = forcedNow ? 1'b1 : chPulse(i, cyc);
        e.busy[i] = chBusy(i, cyc);
      end
      e.cnt = CW'(modelCount);
      if (ForceRaz) begin
        for (int i = 0; i < N; i++) act[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (h1[i] && !h2[i] && ExternalRaz_en && ChannelMask[i] && !chBusy(i, cyc)) begin
            act[i]  = 1'b1;
            accT[i] = cyc;
            dLat[i] = int'(DelayTime);
            wLat[i] = (RazWidth == '0) ? 1 : int'(RazWidth);
            hLat[i] = int'(HoldoffTime);
          end
        end
      end
      enter = 1'b0;
      for (int i = 0; i < N; i++)
        if (act[i] && (accT[i] + 1 + dLat[i] == cyc + 1)) enter = 1'b1;
      if (CountClear) modelCount = 0;
      else if (enter && modelCount < SAT) modelCount++;
    end
    expQ.push_back(e);
    forcedNow = reset_n && ForceRaz;
    @(posedge Clk);
    if (reset_n) begin
      h2 = h1; h1 = h0; h0 = TriggerIn;
    end
    cyc++;
    #1;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycleStep();
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
  always @(negedge Clk) begin
    if (monOn) begin
      if (RAZ_CHN[0] === 1'b1) razObs0++;
      if (Busy[0] === 1'b1) busyObs0++;
      if (expQ.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        me = expQ.pop_front();
        check("raz", 32'(RAZ_CHN), 32'(me.raz));
        check("busy", 32'(Busy), 32'(me.busy));
        check("count", 32'(RazCount), 32'(me.cnt));
      end
    end
  end

  int r0, b0;

  initial begin
    reset_n = 1'b0; TriggerIn = '0; ExternalRaz_en = 1'b1; ChannelMask = 4'hF;
    DelayTime = 6'd3; RazWidth = 8'd10; HoldoffTime = 8'd5; ForceRaz = 1'b0; CountClear = 1'b0;
    h0 = '1; h1 = '1; h2 = '1; forcedNow = 1'b0; modelCount = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; accT[i] = 0; dLat[i] = 0; wLat[i] = 0; hLat[i] = 0; end
    @(posedge Clk); #1;
    monOn = 1'b1;
    run(3);
    reset_n = 1'b1;
    run(5);

    // Single channel timing: delay 3, width 10, holdoff 5.
    r0 = razObs0; b0 = busyObs0;
    TriggerIn[0] = 1'b1; run(30);
    check("basic_raz_cycles", 32'(razObs0 - r0), 32'd10);
    check("basic_busy_cycles", 32'(busyObs0 - b0), 32'd18);
    check("basic_count", 32'(RazCount), 32'd1);
    TriggerIn[0] = 1'b0; run(3);

    // Re-trigger during holdoff is dropped; after Busy falls it is honoured.
    TriggerIn[0] = 1'b1; run(5);
    TriggerIn[0] = 1'b0; run(9);
    TriggerIn[0] = 1'b1; run(20);
    check("holdoff_ignore_count", 32'(RazCount), 32'd2);
    TriggerIn[0] = 1'b0; run(3);
    TriggerIn[0] = 1'b1; run(25);
    check("retrigger_count", 32'(RazCount), 32'd3);
    TriggerIn[0] = 1'b0; run(3);

    // Simultaneous channels: masked, then both enabled; each counts as one event.
    DelayTime = 6'd2; RazWidth = 8'd3; HoldoffTime = 8'd1;
    ChannelMask = 4'b0010; TriggerIn[2:1] = 2'b11; run(12);
    check("mask_count", 32'(RazCount), 32'd4);
    TriggerIn[2:1] = 2'b00; run(3);
    ChannelMask = 4'b0110; TriggerIn[2:1] = 2'b11; run(12);
    check("dual_count", 32'(RazCount), 32'd5);
    TriggerIn[2:1] = 2'b00; run(3);

    // ForceRaz in mid-delay aborts the sequence.
    ChannelMask = 4'hF; DelayTime = 6'd20; RazWidth = 8'd3; HoldoffTime = 8'd0;
    r0 = razObs0;
    TriggerIn[0] = 1'b1; run(6);
    ForceRaz = 1'b1; run(5);
    ForceRaz = 1'b0; run(30);
    check("force_raz_cycles", 32'(razObs0 - r0), 32'd5);
    check("force_count", 32'(RazCount), 32'd5);
    TriggerIn[0] = 1'b0; run(3);

    // Saturation, then clear coincident with an event.
    DelayTime = 6'd0; RazWidth = 8'd1; HoldoffTime = 8'd0;
    for (int k = 0; k < 14; k++) begin
      TriggerIn[0] = 1'b1; run(2);
      TriggerIn[0] = 1'b0; run(2);
    end
    run(2);
    check("saturate_count", 32'(RazCount), 32'(SAT));
    TriggerIn[0] = 1'b1; run(2);
    CountClear = 1'b1; run(1);
    CountClear = 1'b0;
    check("clear_priority", 32'(RazCount), 32'd0);
    TriggerIn[0] = 1'b0; run(3);

    // Reset mid-pulse with trigger held high: no edge until it falls and rises again.
    RazWidth = 8'd20;
    TriggerIn[0] = 1'b1; run(8);
    reset_n = 1'b0; #1;
    check("reset_raz", 32'(RAZ_CHN), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    run(3);
    reset_n = 1'b1;
    r0 = razObs0;
    run(30);
    check("held_trigger_no_raz", 32'(razObs0 - r0), 32'd0);
    check("held_trigger_count", 32'(RazCount), 32'd0);
    TriggerIn[0] = 1'b0; run(3);
    TriggerIn[0] = 1'b1; run(25);
    check("post_reset_count", 32'(RazCount), 32'd1);

    // Randomized traffic checked by the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) TriggerIn[i] = ~TriggerIn[i];
      if ($urandom_range(0, 9) == 0) begin
        DelayTime   = DW'($urandom_range(0, 6));
        RazWidth    = WW'($urandom_range(0, 5));
        HoldoffTime = WW'($urandom_range(0, 4));
      end
      ExternalRaz_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 19) == 0) ChannelMask = N'($urandom_range(0, 15));
      if (ForceRaz) ForceRaz = ($urandom_range(0, 2) != 0);
      else ForceRaz = ($urandom_range(0, 59) == 0);
      CountClear = ($urandom_range(0, 49) == 0);
      if (!reset_n) reset_n = 1'b1;
      else reset_n = ($urandom_range(0, 399) != 0);
      cycleStep();
    end

    monOn = 1'b0;
    @(negedge Clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_raz_generator.md
MULTI_RAZ_GENERATOR -- requirements
Module: multi_raz_generator

Interface
REQ-001 SHALL have parameter N_CHN, default 4, number of independent RAZ channels (1..16).
REQ-002 SHALL have parameter DELAY_W, default 6, width of the trigger-to-RAZ delay field.
REQ-003 SHALL have parameter WIDTH_W, default 8, width of the RAZ pulse-width and holdoff fields.
REQ-004 SHALL have parameter CNT_W, default 16, width of the RAZ event counter.
REQ-005 SHALL have port Clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port TriggerIn  input  N_CHN  asynchronous per-channel trigger levels.
REQ-008 SHALL have port ExternalRaz_en  input  1  global enable for trigger-initiated RAZ.
REQ-009 SHALL have port ChannelMask  input  N_CHN  per-channel enable; 1 = enabled.
REQ-010 SHALL have port DelayTime  input  DELAY_W  delay from accepted edge to RAZ, in cycles.
REQ-011 SHALL have port RazWidth  input  WIDTH_W  RAZ pulse length in cycles.
REQ-012 SHALL have port HoldoffTime  input  WIDTH_W  dead time after each pulse, in cycles.
REQ-013 SHALL have port ForceRaz  input  1  software RAZ of all channels.
REQ-014 SHALL have port CountClear  input  1  synchronous clear of RazCount.
REQ-015 SHALL have port RAZ_CHN  output  N_CHN  registered RAZ outputs to the ASIC chains.
REQ-016 SHALL have port Busy  output  N_CHN  registered; 1 while the channel FSM is not IDLE.
REQ-017 SHALL have port RazCount  output  CNT_W  registered saturating count of RAZ events.

Function
REQ-018 SHALL pass each TriggerIn bit through a 2-flop synchroniser plus one edge-detect flop; edge E_i is true in cycle T when the synchronised level is 1 and the previous level was 0.
REQ-019 SHALL implement per-channel FSM with states IDLE, DELAY, PULSE, HOLDOFF.
REQ-020 SHALL, in IDLE, accept E_i only when ExternalRaz_en=1, ChannelMask[i]=1 and ForceRaz=0, and SHALL ignore it otherwise.
REQ-021 SHALL, on acceptance in cycle T, latch DelayTime, RazWidth and HoldoffTime per channel; later input changes do not affect the sequence in flight.
REQ-022 SHALL assert RAZ_CHN[i] first in cycle T+1+DelayTime, for exactly max(RazWidth,1) consecutive cycles (DelayTime=0 skips DELAY).
REQ-023 SHALL then stay in HOLDOFF for HoldoffTime cycles (0 = return directly to IDLE) with RAZ_CHN[i]=0; a new edge is acceptable from the first cycle Busy[i]=0.
REQ-024 SHALL ignore edges arriving in DELAY, PULSE or HOLDOFF; they are not queued.
REQ-025 SHALL let in-flight sequences complete when ExternalRaz_en or ChannelMask[i] is deasserted mid-sequence.
REQ-026 SHALL, while ForceRaz=1, drive all RAZ_CHN bits 1 from the cycle after ForceRaz rises, abort every FSM to IDLE, and release RAZ_CHN the cycle after ForceRaz falls.
REQ-027 SHALL increment RazCount by exactly 1 in any cycle where one or more channels enter PULSE (simultaneous channels count as one event); ForceRaz is not counted.
REQ-028 SHALL saturate RazCount at all ones, never wrapping.
REQ-029 SHALL give CountClear priority over increment: count becomes 0 the cycle after CountClear, even with a coincident event.
REQ-030 SHALL keep channels fully independent except for the shared counter and ForceRaz.

Reset
REQ-031 SHALL on reset_n=0 immediately force RAZ_CHN=0, Busy=0, RazCount=0 and all FSMs to IDLE, including mid-pulse.
REQ-032 SHALL reset synchroniser and edge-detect flops to 1, so a trigger held high across reset release produces no edge.
REQ-033 SHALL accept the first edge no earlier than the third rising Clk edge after reset_n deassertion.

Verification
REQ-034 SHALL verify: ch0 edge at T, DelayTime=3, RazWidth=10, HoldoffTime=5 -> RAZ_CHN[0]=1 cycles T+4..T+13, Busy[0]=1 T+1..T+18, RazCount=1.
REQ-035 SHALL verify: second ch0 edge during HOLDOFF -> ignored, no RAZ, RazCount unchanged; edge after Busy[0]=0 -> new pulse.
REQ-036 SHALL verify: ch1 and ch2 edges same cycle, ChannelMask=4'b0010 -> only RAZ_CHN[1] pulses, RazCount +1; unmasked both -> both pulse, RazCount +1.
REQ-037 SHALL verify: ForceRaz high 5 cycles mid-DELAY on ch0 -> RAZ_CHN=all ones 5 cycles, ch0 back to IDLE, no delayed pulse, RazCount unchanged.
REQ-038 SHALL verify: RazCount preset to all ones by events -> further event holds all ones; CountClear with coincident event -> 0.
REQ-039 SHALL verify: reset_n pulsed low mid-pulse with TriggerIn[0] held high -> RAZ_CHN=0 at once, no pulse after release until TriggerIn[0] falls and rises.
